// File: rtl/cb_rc_seq_if.sv
// cb_rc_seq_if: command, back-pressure and issue/flag signals of the covariance row/column sequencer
//   master: drives start, row_base, col_base, row_num, col_num, col_major, stall
//   slave : drives busy, CB_row, CB_col, seq_valid, addr_valid, addr_last, addr_trans, done, err
interface cb_rc_seq_if #(parameter int ROW_LEN = 10);
    logic               start;
    logic [ROW_LEN-1:0] row_base;
    logic [ROW_LEN-1:0] col_base;
    logic [ROW_LEN-1:0] row_num;
    logic [ROW_LEN-1:0] col_num;
    logic               col_major;
    logic               stall;
    logic               busy;
    logic [ROW_LEN-1:0] CB_row;
    logic [ROW_LEN-1:0] CB_col;
    logic               seq_valid;
    logic               addr_valid;
    logic               addr_last;
    logic               addr_trans;
    logic               done;
    logic               err;
    modport master (
        output start, row_base, col_base, row_num, col_num, col_major, stall,
        input  busy, CB_row, CB_col, seq_valid, addr_valid, addr_last, addr_trans, done, err
    );
    modport slave (
        input  start, row_base, col_base, row_num, col_num, col_major, stall,
        output busy, CB_row, CB_col, seq_valid, addr_valid, addr_last, addr_trans, done, err
    );
endinterface

// File: rtl/cb_rc_seq.sv
// cb_rc_seq: scans a covariance sub-block, folds upper-triangle pairs onto the lower triangle, aligns flags with AGD latency
//   clk, sys_rst : clock and synchronous active-high reset
//   bus (slave)  : command in, stall in, folded (CB_row, CB_col) pairs and AGD_LAT-delayed valid/last/trans flags out
module cb_rc_seq #(
    parameter int ROW_LEN = 10,
    parameter int MAT_DIM = 1003,
    parameter int AGD_LAT = 5
) (
    input logic        clk,
    input logic        sys_rst,
    cb_rc_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [ROW_LEN:0] lim = (ROW_LEN+1)'(MAT_DIM);
    state_t state;
    logic [ROW_LEN-1:0] rb, cb, rn, cn, r_cnt, c_cnt, r, c;
    logic cm, seq_last, seq_trans, r_wrap, c_wrap, last, swap, zero, bad;
    logic [AGD_LAT-1:0] v_pipe, l_pipe, t_pipe;
    always_comb begin
        r      = rb + r_cnt;
        c      = cb + c_cnt;
        r_wrap = r_cnt == rn - 1'b1;
        c_wrap = c_cnt == cn - 1'b1;
        last   = r_wrap && c_wrap;
        swap   = c > r;
        zero   = bus.row_num == '0 || bus.col_num == '0;
        bad    = ({1'b0, bus.row_base} + {1'b0, bus.row_num}) > lim ||
                 ({1'b0, bus.col_base} + {1'b0, bus.col_num}) > lim;
    end
    assign bus.addr_valid = v_pipe[AGD_LAT-1];
    assign bus.addr_last  = l_pipe[AGD_LAT-1];
    assign bus.addr_trans = t_pipe[AGD_LAT-1];
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.seq_valid <= 1'b0;
            bus.CB_row    <= '0;
            bus.CB_col    <= '0;
            seq_last      <= 1'b0;
            seq_trans     <= 1'b0;
            v_pipe        <= '0;
            l_pipe        <= '0;
            t_pipe        <= '0;
            rb            <= '0;
            cb            <= '0;
            rn            <= '0;
            cn            <= '0;
            cm            <= 1'b0;
            r_cnt         <= '0;
            c_cnt         <= '0;
        end else begin
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.seq_valid <= 1'b0;
            seq_last      <= 1'b0;
            seq_trans     <= 1'b0;
            // Delay lines shift every cycle so stalls appear as bubbles downstream
            v_pipe        <= {v_pipe[AGD_LAT-2:0], bus.seq_valid};
            l_pipe        <= {l_pipe[AGD_LAT-2:0], seq_last};
            t_pipe        <= {t_pipe[AGD_LAT-2:0], seq_trans};
            case (state)
                IDLE: if (bus.start) begin
                    if (zero) begin
                        bus.busy <= 1'b1;
                        state    <= DONE;
                    end else if (bad) begin
                        bus.err <= 1'b1;
                    end else begin
                        rb       <= bus.row_base;
                        cb       <= bus.col_base;
                        rn       <= bus.row_num;
                        cn       <= bus.col_num;
                        cm       <= bus.col_major;
                        r_cnt    <= '0;
                        c_cnt    <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: if (!bus.stall) begin
                    bus.seq_valid <= 1'b1;
                    seq_last      <= last;
                    seq_trans     <= swap;
                    bus.CB_row    <= swap ? c : r;
                    bus.CB_col    <= swap ? r : c;
                    if (last) begin
                        state <= DRAIN;
                    end else if (cm) begin
                        r_cnt <= r_wrap ? '0 : r_cnt + 1'b1;
                        c_cnt <= r_wrap ? c_cnt + 1'b1 : c_cnt;
                    end else begin
                        c_cnt <= c_wrap ? '0 : c_cnt + 1'b1;
                        r_cnt <= c_wrap ? r_cnt + 1'b1 : r_cnt;
                    end
                end
                // Leave once only the final entry remains ahead of the output stage,
                // so done lands the cycle after the last addr_valid
                DRAIN: if (!bus.seq_valid && v_pipe[AGD_LAT-3:0] == '0) state <= DONE;
                default: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
